piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 111 +++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in serial-out word serializer with a 2-entry input FIFO.
// Each entry keeps its own bit order; words stream back-to-back when queued.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             lsb_first,
    output logic             outp,
    output logic             outp_valid,
    output logic             sof,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_nx;

    // each entry is {lsb_first, word}
    logic [WIDTH:0]   mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    logic [WIDTH-1:0] sreg;
    logic             order;
    logic [CW-1:0]    cnt;

    logic             push;
    logic             pop;
    logic             last;

    assign din_ready = rst && (count != 2'd2);
    assign push      = din_valid && din_ready;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign busy      = (state == SHIFT) || (count != 2'd0);

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        outp       = 1'b0;
        outp_valid = 1'b0;
        sof        = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != 2'd0) begin
                    pop      = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                outp_valid = 1'b1;
                outp       = order ? sreg[0] : sreg[WIDTH-1];
                sof        = (cnt == '0);
                if (last) begin
                    if (count != 2'd0) begin
                        pop = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            sreg   <= '0;
            order  <= 1'b0;
            cnt    <= '0;
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (push) begin
                mem[wr_ptr] <= {lsb_first, din};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            // the outgoing bit always sits at the end the order points to
            if (pop) begin
                {order, sreg} <= mem[rd_ptr];
                cnt           <= '0;
            end else if (state == SHIFT) begin
                sreg <= order ? (sreg >> 1) : (sreg << 1);
                cnt  <= last ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule
